posit_decode_pipe: RTL and testbench

//  Streaming, fully parametrised posit decoder (any NBITS/ES). Unpacks raw posit words into

---
 rtl/posit_pkg.sv | 42 ++++
 rtl/posit_lzd.sv | 25 ++
 rtl/posit_decode_pipe.sv | 142 ++++++++++++++
 tb/tb_posit_decode_pipe.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// posit_pkg: shared posit sizing helpers, special-pattern helpers and 32/3 decode records
//   posit_fbits(n,es)      fraction width n-3-es
//   posit_scale_w(n,es)    signed scale width $clog2(n)+es+1
//   posit_nar_pattern(n)   NaR word (1 followed by n-1 zeros), zero-extended to 64 bits
//   posit_is_nar/is_zero   special-word detectors on a zero-extended word
package posit_pkg;
    function automatic int posit_fbits(input int n, input int es);
        return n - 3 - es;
    endfunction
    function automatic int posit_scale_w(input int n, input int es);
        return $clog2(n) + es + 1;
    endfunction
    function automatic logic [63:0] posit_nar_pattern(input int n);
        return 64'd1 << (n - 1);
    endfunction
    function automatic logic posit_is_nar(input logic [63:0] w, input int n);
        return w == posit_nar_pattern(n);
    endfunction
    function automatic logic posit_is_zero(input logic [63:0] w);
        return w == '0;
    endfunction
    localparam int P32_NBITS   = 32;
    localparam int P32_ES      = 3;
    localparam int P32_FBITS   = posit_fbits(P32_NBITS, P32_ES);
    localparam int P32_SCALE_W = posit_scale_w(P32_NBITS, P32_ES);
    typedef struct packed {
        logic                   sign;
        logic [P32_NBITS-1:0]   abs;
        logic                   zero;
        logic                   inf;
        logic                   r0;
        logic [$clog2(P32_NBITS)-1:0] m;
    } posit32_s1_t;
    typedef struct packed {
        logic                   sign;
        logic [P32_SCALE_W-1:0] scale;
        logic [P32_ES-1:0]      exponent;
        logic [P32_FBITS-1:0]   fraction;
        logic                   inf;
        logic                   zero;
    } posit32_dec_t;
endpackage

// File: rtl/posit_lzd.sv
// posit_lzd: length of the run of bits equal to the MSB, counted from the MSB down
//   bits  in  W   word to scan (the posit body below the sign bit)
//   run   out CW  run length, 1..W
module posit_lzd #(
    parameter int W  = 31,
    parameter int CW = 5
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] run
);
    logic [W-1:0] x;
    logic         done;
    // Flipping against the MSB turns the run into leading zeros; x's MSB is always 0.
    always_comb begin
        x = bits ^ {W{bits[W-1]}};
        run = '0;
        done = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!done) begin
                if (x[i]) done = 1'b1;
                else run = run + CW'(1);
            end
        end
    end
endmodule

// File: rtl/posit_decode_pipe.sv
// posit_decode_pipe: 2-stage valid/ready posit decoder into sign/scale/exponent/fraction/inf/zero
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   raw posit word stream
//   out_valid/out_ready         decoded result stream
//   out_sign, out_scale         sign, signed k*2^ES + exponent
//   out_exponent, out_fraction  exponent field, MSB-aligned fraction without hidden bit
//   out_inf, out_zero           NaR / zero flags
//   POSIT_DECODE_STATS_EN adds stat_clr, stat_nar_cnt, stat_zero_cnt (saturating counters)
module posit_decode_pipe
    import posit_pkg::*;
#(
    parameter int   NBITS   = 32,
    parameter int   ES      = 3,
    localparam int  FBITS   = posit_fbits(NBITS, ES),
    localparam int  SCALE_W = posit_scale_w(NBITS, ES),
    localparam int  EW      = ES > 0 ? ES : 1,
    localparam int  CW      = $clog2(NBITS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NBITS-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sign,
    output logic [SCALE_W-1:0] out_scale,
    output logic [EW-1:0]      out_exponent,
    output logic [FBITS-1:0]   out_fraction,
    output logic               out_inf,
    output logic               out_zero
`ifdef POSIT_DECODE_STATS_EN
   ,input  logic               stat_clr,
    output logic [31:0]        stat_nar_cnt,
    output logic [31:0]        stat_zero_cnt
`endif
);
    logic                      live;
    logic                      s1_valid, s1_sign, s1_zero, s1_inf, s1_r0;
    logic [NBITS-1:0]          s1_abs;
    logic [CW-1:0]             s1_m;
    logic                      s1_adv, s2_adv, take;
    logic                      in_sign;
    logic [NBITS-1:0]          in_abs;
    logic [CW-1:0]             in_m;
    logic [CW:0]               sh_amt;
    logic [NBITS-4:0]          body;
    logic [EW-1:0]             exp_f;
    logic [FBITS-1:0]          frac_f;
    logic signed [SCALE_W-1:0] m_s, k, scale;
    logic                      special;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    // live holds in_ready low until the first edge after reset release
    assign in_ready = live && s1_adv;
    assign take     = in_valid && in_ready;
    assign in_sign  = in_data[NBITS-1];
    assign in_abs   = in_sign ? -in_data : in_data;

    posit_lzd #(.W(NBITS - 1), .CW(CW)) u_lzd (
        .bits (in_abs[NBITS-2:0]),
        .run  (in_m)
    );

    // Sign, regime and terminator occupy the top m+2 bits; the bottom 3 bits of the
    // shifted word are always zero so only NBITS-3 bits carry exponent and fraction.
    always_comb begin
        sh_amt  = {1'b0, s1_m} + (CW + 1)'(2);
        body    = (NBITS - 3)'((s1_abs << sh_amt) >> 3);
        exp_f   = ES > 0 ? body[NBITS-4 -: EW] : '0;
        frac_f  = body[FBITS-1:0];
        m_s     = SCALE_W'(s1_m);
        k       = s1_r0 ? m_s - SCALE_W'(1) : -m_s;
        scale   = (k <<< ES) + SCALE_W'(exp_f);
        special = s1_zero || s1_inf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) live <= 1'b0;
        else live <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_abs   <= '0;
            s1_zero  <= 1'b0;
            s1_inf   <= 1'b0;
            s1_r0    <= 1'b0;
            s1_m     <= '0;
        end else if (s1_adv) begin
            s1_valid <= take;
            if (take) begin
                s1_sign <= in_sign;
                s1_abs  <= in_abs;
                s1_zero <= posit_is_zero(64'(in_data));
                s1_inf  <= posit_is_nar(64'(in_data), NBITS);
                s1_r0   <= in_abs[NBITS-2];
                s1_m    <= in_m;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_sign     <= 1'b0;
            out_scale    <= '0;
            out_exponent <= '0;
            out_fraction <= '0;
            out_inf      <= 1'b0;
            out_zero     <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sign     <= s1_sign;
                out_scale    <= special ? '0 : scale;
                out_exponent <= special ? '0 : exp_f;
                out_fraction <= special ? '0 : frac_f;
                out_inf      <= s1_inf;
                out_zero     <= s1_zero;
            end
        end
    end

`ifdef POSIT_DECODE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_nar_cnt  <= '0;
            stat_zero_cnt <= '0;
        end else if (stat_clr) begin
            stat_nar_cnt  <= '0;
            stat_zero_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (out_inf && stat_nar_cnt != '1) stat_nar_cnt <= stat_nar_cnt + 32'd1;
            if (out_zero && stat_zero_cnt != '1) stat_zero_cnt <= stat_zero_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_posit_decode_pipe.sv
// tb_posit_decode_pipe: checks 32/3 and 16/1 decoders against tables and a bit-walking model
module tb_posit_decode_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] d32 = '0;
    logic [15:0] d16 = '0;
    logic        ir32, ov32, os32, oi32, oz32;
    logic [8:0]  sc32;
    logic [2:0]  ex32;
    logic [25:0] fr32;
    logic        ir16, ov16, os16, oi16, oz16;
    logic [5:0]  sc16;
    logic [0:0]  ex16;
    logic [11:0] fr16;
`ifdef POSIT_DECODE_STATS_EN
    logic        stat_clr = 1'b0;
    logic [31:0] nar32, zero32, nar16, zero16;
    int          exp_nar = 0, exp_zero = 0;
`endif

    always #5 clk = ~clk;

    posit_decode_pipe #(.NBITS(32), .ES(3)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32), .in_data(d32),
        .out_valid(ov32), .out_ready(out_ready), .out_sign(os32), .out_scale(sc32),
        .out_exponent(ex32), .out_fraction(fr32), .out_inf(oi32), .out_zero(oz32)
`ifdef POSIT_DECODE_STATS_EN
       ,.stat_clr(stat_clr), .stat_nar_cnt(nar32), .stat_zero_cnt(zero32)
`endif
    );

    posit_decode_pipe #(.NBITS(16), .ES(1)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16), .in_data(d16),
        .out_valid(ov16), .out_ready(out_ready), .out_sign(os16), .out_scale(sc16),
        .out_exponent(ex16), .out_fraction(fr16), .out_inf(oi16), .out_zero(oz16)
`ifdef POSIT_DECODE_STATS_EN
       ,.stat_clr(stat_clr), .stat_nar_cnt(nar16), .stat_zero_cnt(zero16)
`endif
    );

    typedef struct packed {
        bit     sign;
        int     scale;
        int     exponent;
        longint fraction;
        bit     inf;
        bit     zero;
    } res_t;

    typedef struct {
        int          n;
        logic [31:0] w;
        res_t        e;
    } vec_t;

    int   checks = 0, failures = 0, cyc = 0, acc = 0;
    bit   lat_on = 1'b0;
    res_t q32[$];
    res_t q16[$];
    int   qt[$];
    vec_t tbl[16];

    // Reference: walk the posit bit by bit from the MSB (sign, regime run, terminator, fields).
    function automatic res_t ref_dec(input longint unsigned w, input int n, input int es);
        res_t            r;
        longint unsigned md, a;
        int              p, m, k;
        bit              r0;
        r  = '0;
        md = 64'd1 << n;
        w  = w % md;
        if (w == 0) begin
            r.zero = 1'b1;
            return r;
        end
        if (w == md / 2) begin
            r.inf  = 1'b1;
            r.sign = 1'b1;
            return r;
        end
        r.sign = w >= md / 2;
        a  = r.sign ? md - w : w;
        r0 = bit'((a >> (n - 2)) & 1);
        p  = n - 2;
        m  = 0;
        while (p >= 0 && bit'((a >> p) & 1) == r0) begin
            m++;
            p--;
        end
        k = r0 ? m - 1 : -m;
        p--;
        for (int j = 0; j < es; j++) begin
            r.exponent = r.exponent * 2 + ((p >= 0) ? int'((a >> p) & 1) : 0);
            p--;
        end
        for (int j = 0; j < n - 3 - es; j++) begin
            r.fraction = r.fraction * 2 + ((p >= 0) ? longint'((a >> p) & 1) : 0);
            p--;
        end
        r.scale = k * (1 << es) + r.exponent;
        return r;
    endfunction

    function automatic res_t got32();
        res_t r;
        r.sign = os32; r.scale = int'($signed(sc32)); r.exponent = int'(ex32);
        r.fraction = longint'(fr32); r.inf = oi32; r.zero = oz32;
        return r;
    endfunction

    function automatic res_t got16();
        res_t r;
        r.sign = os16; r.scale = int'($signed(sc16)); r.exponent = int'(ex16);
        r.fraction = longint'(fr16); r.inf = oi16; r.zero = oz16;
        return r;
    endfunction

    function automatic vec_t mk(input int n, input logic [31:0] w, input bit s, input int sc,
                                input int ex, input longint fr, input bit inf, input bit z);
        vec_t v;
        v.n = n; v.w = w;
        v.e.sign = s; v.e.scale = sc; v.e.exponent = ex; v.e.fraction = fr;
        v.e.inf = inf; v.e.zero = z;
        return v;
    endfunction

    task automatic chk(input string nm, input res_t g, input res_t e);
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s got s=%0d sc=%0d ex=%0d fr=%0h inf=%0d z=%0d want s=%0d sc=%0d ex=%0d fr=%0h inf=%0d z=%0d",
                     nm, g.sign, g.scale, g.exponent, g.fraction, g.inf, g.zero,
                     e.sign, e.scale, e.exponent, e.fraction, e.inf, e.zero);
        end
    endtask

    task automatic chk_int(input string nm, input longint g, input longint e);
        checks++;
        if (g != e) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, g, e);
        end
    endtask

    task automatic monitor();
        res_t e;
        int   t0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ov32 && out_ready) begin
                    if (q32.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL spurious32 got out_valid=1 want no pending word");
                    end else begin
                        e  = q32.pop_front();
                        t0 = qt.pop_front();
                        chk("stream32", got32(), e);
                        if (lat_on) chk_int("latency32", cyc - t0, 2);
`ifdef POSIT_DECODE_STATS_EN
                        if (e.inf) exp_nar++;
                        if (e.zero) exp_zero++;
`endif
                    end
                end
                if (ov16 && out_ready) begin
                    if (q16.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL spurious16 got out_valid=1 want no pending word");
                    end else chk("stream16", got16(), q16.pop_front());
                end
                if (in_valid && ir32) begin
                    q32.push_back(ref_dec(64'(d32), 32, 3));
                    qt.push_back(cyc);
                    acc++;
                end
                if (in_valid && ir16) q16.push_back(ref_dec(64'(d16), 16, 1));
            end
            cyc++;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the word was accepted.
    task automatic send(input logic [31:0] a, input logic [15:0] b);
        int t;
        in_valid = 1'b1;
        d32 = a;
        d16 = b;
        t = 0;
        @(negedge clk);
        while (!ir32 && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (t >= 100) begin
            checks++; failures++;
            $display("FAIL send_timeout got in_ready=0 want 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
        chk_int("drain_q32", q32.size(), 0);
        chk_int("drain_q16", q16.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wa, wb, wc;
        logic [15:0] ha, hb, hc;
        int          a0, c0, t;
        fork
            monitor();
        join_none

        tbl[0]  = mk(32, 32'h40000000, 0,    0, 0, 0, 0, 0);
        tbl[1]  = mk(32, 32'h48000000, 0,    2, 2, 0, 0, 0);
        tbl[2]  = mk(32, 32'hC0000000, 1,    0, 0, 0, 0, 0);
        tbl[3]  = mk(32, 32'h00000000, 0,    0, 0, 0, 0, 1);
        tbl[4]  = mk(32, 32'h80000000, 1,    0, 0, 0, 1, 0);
        tbl[5]  = mk(32, 32'h7FFFFFFF, 0,  240, 0, 0, 0, 0);
        tbl[6]  = mk(32, 32'h00000001, 0, -240, 0, 0, 0, 0);
        tbl[7]  = mk(32, 32'h40000001, 0,    0, 0, 1, 0, 0);
        tbl[8]  = mk(32, 32'hB8000000, 1,    2, 2, 0, 0, 0);
        tbl[9]  = mk(16, 32'h4000,     0,    0, 0, 0, 0, 0);
        tbl[10] = mk(16, 32'h7FFF,     0,   28, 0, 0, 0, 0);
        tbl[11] = mk(16, 32'h0001,     0,  -28, 0, 0, 0, 0);
        tbl[12] = mk(16, 32'h8000,     1,    0, 0, 0, 1, 0);
        tbl[13] = mk(16, 32'h0000,     0,    0, 0, 0, 0, 1);
        tbl[14] = mk(16, 32'h5000,     0,    1, 1, 0, 0, 0);
        tbl[15] = mk(16, 32'h4800,     0,    0, 0, 'h800, 0, 0);

        // reset state and in_ready release
        repeat (3) @(posedge clk);
        #1;
        chk_int("reset_in_ready", ir32, 0);
        chk_int("reset_out_valid", ov32, 0);
        chk("reset_out32", got32(), '0);
        chk("reset_out16", got16(), '0);
        #2 rst_n = 1'b1;
        #1 chk_int("pre_edge_in_ready", ir32, 0);
        @(posedge clk);
        #1 chk_int("post_edge_in_ready", ir32, 1);

        // directed table, one word at a time
        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            d32 = tbl[i].n == 32 ? tbl[i].w : $urandom;
            d16 = tbl[i].n == 16 ? tbl[i].w[15:0] : 16'($urandom);
            @(posedge clk);
            #1 in_valid = 1'b0;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(tbl[i].n == 32 ? ov32 : ov16) && t < 6);
            chk_int("table_latency", t, 2);
            chk($sformatf("table%0d_%0h", i, tbl[i].w), tbl[i].n == 32 ? got32() : got16(), tbl[i].e);
        end
        drain();

        // 100 back-to-back random words, full rate, fixed latency
        lat_on = 1'b1;
        a0 = acc;
        c0 = cyc;
        for (int i = 0; i < 100; i++) send($urandom, 16'($urandom));
        chk_int("throughput_cycles", cyc - c0, 100);
        drain();
        lat_on = 1'b0;
        chk_int("accepted100", acc - a0, 100);

        // three words against a stalled output
        out_ready = 1'b0;
        wa = $urandom; wb = $urandom; wc = $urandom;
        ha = 16'($urandom); hb = 16'($urandom); hc = 16'($urandom);
        a0 = acc;
        send(wa, ha);
        send(wb, hb);
        in_valid = 1'b1;
        d32 = wc;
        d16 = hc;
        repeat (5) begin
            @(negedge clk);
            chk_int("stall_in_ready", ir32, 0);
            chk_int("stall_out_valid", ov32, 1);
            chk("stall_hold32", got32(), ref_dec(64'(wa), 32, 3));
            chk("stall_hold16", got16(), ref_dec(64'(ha), 16, 1));
        end
        chk_int("stall_accepted", acc - a0, 2);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(wc, hc);
        drain();

        // random gaps and random backpressure
        fork
            begin
                repeat (300) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
            for (int i = 0; i < 80; i++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send($urandom, 16'($urandom));
            end
        join
        out_ready = 1'b1;
        drain();

        // reset in the middle of a stream
        for (int i = 0; i < 6; i++) send($urandom, 16'($urandom));
        #2 chk_int("pre_reset_out_valid", ov32, 1);
        rst_n = 1'b0;
        #1;
        chk_int("mid_reset_out_valid32", ov32, 0);
        chk_int("mid_reset_out_valid16", ov16, 0);
        chk_int("mid_reset_in_ready", ir32, 0);
        chk("mid_reset_out32", got32(), '0);
        q32.delete();
        q16.delete();
        qt.delete();
`ifdef POSIT_DECODE_STATS_EN
        exp_nar = 0;
        exp_zero = 0;
`endif
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 chk_int("post_reset_in_ready", ir32, 1);
        lat_on = 1'b1;
        for (int i = 0; i < 30; i++) send($urandom, 16'($urandom));
        drain();
        lat_on = 1'b0;

`ifdef POSIT_DECODE_STATS_EN
        repeat (3) send(32'h80000000, 16'h8000);
        repeat (2) send(32'h00000000, 16'h0000);
        drain();
        chk_int("stat_nar", nar32, exp_nar);
        chk_int("stat_zero", zero32, exp_zero);
        chk_int("stat_nar16", nar16, 3);
        chk_int("stat_zero16", zero16, 2);
        send(32'h80000000, 16'h8000);
        @(posedge clk);
        #1 stat_clr = 1'b1;
        @(posedge clk);
        #1 stat_clr = 1'b0;
        exp_nar = 0;
        exp_zero = 0;
        chk_int("stat_clr_nar", nar32, 0);
        chk_int("stat_clr_zero", zero32, 0);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
